// File: rtl/l1_cache_pkg.sv
// Shared L1 cache types: MSHR entry record, rw encoding, line-address helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package l1_cache_pkg;

    localparam int L1_ADDR_W = 32;
    localparam int L1_DATA_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic [L1_ADDR_W-1:0] addr;
        logic                 rw;
        logic [L1_DATA_W-1:0] wdata;
        logic                 valid;
    } mshr_entry_t;

    // Line number: byte address with the line offset shifted out.
    function automatic logic [L1_ADDR_W-1:0] line_addr(input logic [L1_ADDR_W-1:0] addr,
                                                       input int offset_w);
        return addr >> offset_w;
    endfunction

    // Line-aligned byte address: low offset_w bits forced to zero.
    function automatic logic [L1_ADDR_W-1:0] line_base(input logic [L1_ADDR_W-1:0] addr,
                                                       input int offset_w);
        return (addr >> offset_w) << offset_w;
    endfunction

endpackage

// File: rtl/l1_mshr_queue_if.sv
// Bundle between lookup stage / miss FSM (master) and the MSHR queue (slave).
// Latency: n/a (wires only).
// Backpressure: full/block tell the master to stop allocating.
// Ports: lk_* lookup, alloc* allocation, mshr_read_next/get/del FSM strobes,
//        issue_* / get_* entry data, status flags and count back to the master.
interface l1_mshr_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              lk_valid;
    logic [ADDR_W-1:0] lk_addr;
    logic              alloc;
    logic              alloc_rw;
    logic [DATA_W-1:0] alloc_wdata;
    logic              mshr_read_next;
    logic              mshr_get;
    logic              mshr_del;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_rw;
    logic [ADDR_W-1:0] get_addr;
    logic              get_rw;
    logic [DATA_W-1:0] get_wdata;
    logic              mshr_empty;
    logic              mshr_idle;
    logic              full;
    logic              block;
    logic              same_line;
    logic              prev_read;
    logic [CNT_W-1:0]  count;

    modport master (
        output lk_valid, lk_addr, alloc, alloc_rw, alloc_wdata,
               mshr_read_next, mshr_get, mshr_del,
        input  issue_addr, issue_rw, get_addr, get_rw, get_wdata,
               mshr_empty, mshr_idle, full, block, same_line, prev_read, count
    );

    modport slave (
        input  lk_valid, lk_addr, alloc, alloc_rw, alloc_wdata,
               mshr_read_next, mshr_get, mshr_del,
        output issue_addr, issue_rw, get_addr, get_rw, get_wdata,
               mshr_empty, mshr_idle, full, block, same_line, prev_read, count
    );

endinterface

// File: rtl/mshr_line_cam.sv
// DEPTH-way line-address comparator: lookup line vs every valid MSHR entry.
// Latency: combinational.
// Backpressure: none.
// Ports: lk_addr lookup byte address, entry_addr/entry_vld per-entry state, hit per-entry match.
module mshr_line_cam
    import l1_cache_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4
) (
    input  logic [ADDR_W-1:0]            lk_addr,
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [DEPTH-1:0]             entry_vld,
    output logic [DEPTH-1:0]             hit
);

    logic [L1_ADDR_W-1:0] lk_line;

    assign lk_line = line_addr(L1_ADDR_W'(lk_addr), OFFSET_W);

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = entry_vld[i] &&
                     (line_addr(L1_ADDR_W'(entry_addr[i]), OFFSET_W) == lk_line);
        end
    end

endmodule

// File: rtl/l1_mshr_queue.sv
// MSHR queue: in-order miss allocation, issue to L2, retire on fill.
// Latency: issue_*/get_*/status registered, valid the cycle after the strobe; same_line/block combinational.
// Backpressure: alloc dropped while full; block asks the processor to stall.
// Ports: clock, reset (async active-low), mq slave side of l1_mshr_queue_if.
module l1_mshr_queue
    import l1_cache_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = L1_ADDR_W,
    parameter int DATA_W   = L1_DATA_W,
    parameter int OFFSET_W = 4
) (
    input  logic          clock,
    input  logic          reset,
    l1_mshr_queue_if.slave mq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mshr_entry_t ent [DEPTH];

    logic [PTR_W-1:0] wr_ptr, iss_ptr, ret_ptr;
    logic [CNT_W-1:0] n_valid, n_unissued;
    logic [CNT_W-1:0] n_valid_nxt, n_unissued_nxt;

    logic full_q, empty_q, idle_q, prev_read_q;

    logic has_unissued, has_issued;
    logic alloc_ok, rd_ok, get_ok, del_ok;

    logic [DEPTH-1:0][ADDR_W-1:0] cam_addr;
    logic [DEPTH-1:0]             cam_vld;
    logic [DEPTH-1:0]             cam_hit;
    logic                         same_line;

    // Issued entries are those between ret_ptr and iss_ptr.
    assign has_unissued = (n_unissued != '0);
    assign has_issued   = (n_valid != n_unissued);

    // full_q reflects the state before this cycle's del, so alloc+del while full drops the alloc.
    assign alloc_ok = mq.lk_valid & mq.alloc & ~full_q;
    assign rd_ok    = mq.mshr_read_next & has_unissued;
    assign get_ok   = mq.mshr_get & has_issued;
    assign del_ok   = mq.mshr_del & has_issued;

    assign n_valid_nxt    = n_valid + CNT_W'(alloc_ok) - CNT_W'(del_ok);
    assign n_unissued_nxt = n_unissued + CNT_W'(alloc_ok) - CNT_W'(rd_ok);

    always_comb begin
        cam_addr = '0;
        cam_vld  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cam_addr[i] = ADDR_W'(ent[i].addr);
            cam_vld[i]  = ent[i].valid;
        end
    end

    mshr_line_cam #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .OFFSET_W(OFFSET_W)
    ) u_cam (
        .lk_addr   (mq.lk_addr),
        .entry_addr(cam_addr),
        .entry_vld (cam_vld),
        .hit       (cam_hit)
    );

    assign same_line    = mq.lk_valid & (|cam_hit);
    assign mq.same_line = same_line;
    // A write to a line with a pending miss must wait so the fill does not overwrite it.
    assign mq.block     = full_q | (same_line & (mq.alloc_rw == RW_WRITE));

    assign mq.full       = full_q;
    assign mq.mshr_empty = empty_q;
    assign mq.mshr_idle  = idle_q;
    assign mq.prev_read  = prev_read_q;
    assign mq.count      = n_valid;

    // Entry storage. wr_ptr and ret_ptr only coincide when empty (no del) or full (no alloc).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (del_ok) begin
                ent[ret_ptr].valid <= 1'b0;
            end
            if (alloc_ok) begin
                ent[wr_ptr] <= '{addr:  L1_ADDR_W'(mq.lk_addr),
                                 rw:    mq.alloc_rw,
                                 wdata: L1_DATA_W'(mq.alloc_wdata),
                                 valid: 1'b1};
            end
        end
    end

    // Pointers, counters and registered status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            iss_ptr     <= '0;
            ret_ptr     <= '0;
            n_valid     <= '0;
            n_unissued  <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            idle_q      <= 1'b1;
            prev_read_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(alloc_ok);
            iss_ptr    <= iss_ptr + PTR_W'(rd_ok);
            ret_ptr    <= ret_ptr + PTR_W'(del_ok);
            n_valid    <= n_valid_nxt;
            n_unissued <= n_unissued_nxt;
            full_q     <= (n_valid_nxt == CNT_W'(DEPTH));
            empty_q    <= (n_unissued_nxt == '0);
            idle_q     <= (n_valid_nxt == '0);
            if (alloc_ok) begin
                prev_read_q <= (mq.alloc_rw == RW_READ);
            end else if (del_ok && (n_valid_nxt == '0)) begin
                prev_read_q <= 1'b0;
            end
        end
    end

    // Issue and retire data registers; they hold when the strobe is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.issue_addr <= '0;
            mq.issue_rw   <= 1'b0;
            mq.get_addr   <= '0;
            mq.get_rw     <= 1'b0;
            mq.get_wdata  <= '0;
        end else begin
            if (rd_ok) begin
                mq.issue_addr <= ADDR_W'(line_base(ent[iss_ptr].addr, OFFSET_W));
                mq.issue_rw   <= ent[iss_ptr].rw;
            end
            // Reads the entry as it stands before any same-cycle del.
            if (get_ok) begin
                mq.get_addr  <= ADDR_W'(ent[ret_ptr].addr);
                mq.get_rw    <= ent[ret_ptr].rw;
                mq.get_wdata <= DATA_W'(ent[ret_ptr].wdata);
            end
        end
    end

endmodule

// File: tb/tb_l1_mshr_queue.sv
// Directed bench for l1_mshr_queue: table of vectors, async-reset and ignore sequences, wrap loop.
// Latency: checks combinational outputs before the edge, registered outputs 1 ns after.
// Backpressure: full/drop and block cases covered in the table.
module tb_l1_mshr_queue;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    l1_mshr_queue_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

    l1_mshr_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .OFFSET_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .mq   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        lkv;
        logic [31:0] addr;
        logic        al;
        logic        rw;
        logic [31:0] wd;
        logic        rn;
        logic        g;
        logic        d;
        logic        e_sl;
        logic        e_blk;
        logic [2:0]  e_cnt;
        logic        e_emp;
        logic        e_idl;
        logic        e_ful;
        logic        e_prv;
        logic [31:0] e_ia;
        logic        e_irw;
        logic [31:0] e_ga;
        logic        e_grw;
        logic [31:0] e_gwd;
    } vec_t;

    function automatic vec_t mk(input logic lkv, input logic [31:0] addr, input logic al,
                                input logic rw, input logic [31:0] wd, input logic rn,
                                input logic g, input logic d, input logic sl, input logic blk,
                                input logic [2:0] cnt, input logic emp, input logic idl,
                                input logic ful, input logic prv, input logic [31:0] ia,
                                input logic irw, input logic [31:0] ga, input logic grw,
                                input logic [31:0] gwd);
        vec_t v;
        v.lkv = lkv;  v.addr = addr; v.al = al; v.rw = rw; v.wd = wd;
        v.rn = rn;    v.g = g;       v.d = d;
        v.e_sl = sl;  v.e_blk = blk; v.e_cnt = cnt; v.e_emp = emp; v.e_idl = idl;
        v.e_ful = ful; v.e_prv = prv; v.e_ia = ia; v.e_irw = irw;
        v.e_ga = ga;  v.e_grw = grw; v.e_gwd = gwd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.lk_valid       = v.lkv;
        bus.lk_addr        = v.addr;
        bus.alloc          = v.al;
        bus.alloc_rw       = v.rw;
        bus.alloc_wdata    = v.wd;
        bus.mshr_read_next = v.rn;
        bus.mshr_get       = v.g;
        bus.mshr_del       = v.d;
    endtask

    task automatic clear_in();
        bus.lk_valid       = 1'b0;
        bus.lk_addr        = '0;
        bus.alloc          = 1'b0;
        bus.alloc_rw       = 1'b0;
        bus.alloc_wdata    = '0;
        bus.mshr_read_next = 1'b0;
        bus.mshr_get       = 1'b0;
        bus.mshr_del       = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [2:0] cnt, input logic emp,
                              input logic idl, input logic ful, input logic prv);
        chk({tag, ".count"}, 64'(bus.count), 64'(cnt));
        chk({tag, ".empty"}, 64'(bus.mshr_empty), 64'(emp));
        chk({tag, ".idle"}, 64'(bus.mshr_idle), 64'(idl));
        chk({tag, ".full"}, 64'(bus.full), 64'(ful));
        chk({tag, ".prev_read"}, 64'(bus.prev_read), 64'(prv));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clock);
        drive(v);
        #1;
        chk({tag, ".same_line"}, 64'(bus.same_line), 64'(v.e_sl));
        chk({tag, ".block"}, 64'(bus.block), 64'(v.e_blk));
        @(posedge clock);
        #1;
        chk_status(tag, v.e_cnt, v.e_emp, v.e_idl, v.e_ful, v.e_prv);
        chk({tag, ".issue_addr"}, 64'(bus.issue_addr), 64'(v.e_ia));
        chk({tag, ".issue_rw"}, 64'(bus.issue_rw), 64'(v.e_irw));
        chk({tag, ".get_addr"}, 64'(bus.get_addr), 64'(v.e_ga));
        chk({tag, ".get_rw"}, 64'(bus.get_rw), 64'(v.e_grw));
        chk({tag, ".get_wdata"}, 64'(bus.get_wdata), 64'(v.e_gwd));
        clear_in();
    endtask

    task automatic sync_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    vec_t tbl [19];

    // Reference model for the wrap loop: queues of {rw, addr}.
    logic [32:0] uq [$];
    logic [32:0] iq [$];

    initial begin
        clear_in();

        // Table:      lkv addr          al rw wdata         rn g  d  | sl blk cnt emp idl ful prv issue_addr   irw get_addr     grw get_wdata
        tbl[0]  = mk(1, 32'h0000_1234, 1, 0, 32'h0,        0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 32'h0,        0, 32'h0,      0, 32'h0);
        tbl[1]  = mk(0, 32'h0,         0, 0, 32'h0,        1, 0, 0,  0, 0, 1, 1, 0, 0, 1, 32'h0000_1230, 0, 32'h0,      0, 32'h0);
        tbl[2]  = mk(1, 32'h0000_2000, 1, 1, 32'hDEADBEEF, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 32'h0000_1230, 0, 32'h0,      0, 32'h0);
        tbl[3]  = mk(1, 32'h0000_123C, 0, 0, 32'h0,        0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 32'h0000_1230, 0, 32'h0,      0, 32'h0);
        tbl[4]  = mk(1, 32'h0000_1240, 0, 1, 32'h0,        0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 32'h0000_1230, 0, 32'h0,      0, 32'h0);
        tbl[5]  = mk(1, 32'h0000_1238, 0, 1, 32'h0,        0, 0, 0,  1, 1, 2, 0, 0, 0, 0, 32'h0000_1230, 0, 32'h0,      0, 32'h0);
        tbl[6]  = mk(0, 32'h0,         0, 0, 32'h0,        0, 1, 1,  0, 0, 1, 0, 0, 0, 0, 32'h0000_1230, 0, 32'h0000_1234, 0, 32'h0);
        tbl[7]  = mk(0, 32'h0,         0, 0, 32'h0,        1, 0, 0,  0, 0, 1, 1, 0, 0, 0, 32'h0000_2000, 1, 32'h0000_1234, 0, 32'h0);
        tbl[8]  = mk(0, 32'h0,         0, 0, 32'h0,        0, 1, 1,  0, 0, 0, 1, 1, 0, 0, 32'h0000_2000, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[9]  = mk(1, 32'h0000_3000, 1, 0, 32'h0,        0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 32'h0000_2000, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[10] = mk(1, 32'h0000_3010, 1, 1, 32'h11,       0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 32'h0000_2000, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[11] = mk(1, 32'h0000_3020, 1, 0, 32'h0,        0, 0, 0,  0, 0, 3, 0, 0, 0, 1, 32'h0000_2000, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[12] = mk(1, 32'h0000_3030, 1, 1, 32'h22,       0, 0, 0,  0, 0, 4, 0, 0, 1, 0, 32'h0000_2000, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[13] = mk(1, 32'h0000_4000, 1, 0, 32'h0,        0, 0, 0,  0, 1, 4, 0, 0, 1, 0, 32'h0000_2000, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[14] = mk(0, 32'h0,         0, 0, 32'h0,        1, 0, 0,  0, 1, 4, 0, 0, 1, 0, 32'h0000_3000, 0, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[15] = mk(1, 32'h0000_5000, 1, 1, 32'h0,        0, 0, 1,  0, 1, 3, 0, 0, 0, 0, 32'h0000_3000, 0, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[16] = mk(0, 32'h0,         0, 0, 32'h0,        1, 0, 0,  0, 0, 3, 0, 0, 0, 0, 32'h0000_3010, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[17] = mk(1, 32'h0000_5004, 1, 0, 32'h0,        0, 0, 1,  0, 0, 3, 0, 0, 0, 1, 32'h0000_3010, 1, 32'h0000_2000, 1, 32'hDEADBEEF);
        tbl[18] = mk(0, 32'h0,         0, 0, 32'h0,        1, 0, 0,  0, 0, 3, 0, 0, 0, 1, 32'h0000_3020, 0, 32'h0000_2000, 1, 32'hDEADBEEF);

        // Reset state while reset is held.
        repeat (2) @(posedge clock);
        #1;
        chk_status("rst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst.block", 64'(bus.block), 64'd0);
        chk("rst.issue_addr", 64'(bus.issue_addr), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Async reset with 3 valid entries, one issued: outputs clear without an edge.
        @(posedge clock);
        #2;
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 32'h0000_3024;
        bus.alloc_rw = 1'b1;
        #0.5;
        chk("pre_arst.same_line", 64'(bus.same_line), 64'd1);
        reset = 1'b0;
        #1;
        chk_status("arst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("arst.same_line", 64'(bus.same_line), 64'd0);
        chk("arst.block", 64'(bus.block), 64'd0);
        chk("arst.issue_addr", 64'(bus.issue_addr), 64'd0);
        chk("arst.get_wdata", 64'(bus.get_wdata), 64'd0);
        clear_in();
        @(negedge clock);
        reset = 1'b1;

        // Strobes with no entries are ignored.
        apply(mk(0, 32'h0, 0, 0, 32'h0, 1, 1, 1,  0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0), "ign");
        // alloc + read_next with nothing unissued: no bypass.
        apply(mk(1, 32'h0000_7778, 1, 1, 32'hCAFEF00D, 1, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0), "nobyp");
        apply(mk(0, 32'h0, 0, 0, 32'h0, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0, 32'h0000_7770, 1, 32'h0, 0, 32'h0), "iss2");
        apply(mk(0, 32'h0, 0, 0, 32'h0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 32'h0000_7770, 1, 32'h0000_7778, 1, 32'hCAFEF00D), "get2");
        apply(mk(0, 32'h0, 0, 0, 32'h0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0, 32'h0000_7770, 1, 32'h0000_7778, 1, 32'hCAFEF00D), "del2");

        // Wrap loop against a queue model.
        sync_reset();
        begin
            logic [31:0] exp_ia;
            logic [31:0] exp_ga;
            logic        exp_prv;
            exp_ia  = '0;
            exp_ga  = '0;
            exp_prv = 1'b0;
            uq.delete();
            iq.delete();
            for (int i = 0; i < 24; i++) begin
                logic        al, rw, rn, gd, acc, rn_ok, g_ok;
                logic [31:0] a;
                int          n;
                al = (i % 4) != 3;
                rw = i[0];
                rn = (i % 3) != 0;
                gd = (i % 2) == 1;
                a  = 32'h0000_8000 + 32'(i) * 32'h24;
                n     = uq.size() + iq.size();
                acc   = al && (n != 4);
                rn_ok = rn && (uq.size() != 0);
                g_ok  = gd && (iq.size() != 0);
                if (rn_ok) exp_ia = uq[0][31:0] & 32'hFFFF_FFF0;
                if (g_ok)  exp_ga = iq[0][31:0];
                if (g_ok)  void'(iq.pop_front());
                if (rn_ok) iq.push_back(uq.pop_front());
                if (acc) begin
                    uq.push_back({rw, a});
                    exp_prv = ~rw;
                end else if (g_ok && (uq.size() + iq.size() == 0)) begin
                    exp_prv = 1'b0;
                end
                @(negedge clock);
                bus.lk_valid       = al;
                bus.lk_addr        = a;
                bus.alloc          = al;
                bus.alloc_rw       = rw;
                bus.alloc_wdata    = 32'(i);
                bus.mshr_read_next = rn;
                bus.mshr_get       = gd;
                bus.mshr_del       = gd;
                @(posedge clock);
                #1;
                n = uq.size() + iq.size();
                chk_status($sformatf("w%0d", i), 3'(n), uq.size() == 0, n == 0, n == 4, exp_prv);
                chk($sformatf("w%0d.issue_addr", i), 64'(bus.issue_addr), 64'(exp_ia));
                chk($sformatf("w%0d.get_addr", i), 64'(bus.get_addr), 64'(exp_ga));
                clear_in();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
